// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types and helpers for the tristate bus arbiter.
package tristate_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

  // Width of an owner index; never below one bit so ports stay legal.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Requester/arbiter bundle: level requests and drive data in, grant and tristate controls out.
interface tristate_bus_arbiter_if
  import tristate_arb_pkg::*;
#(
  parameter int N_REQ = 4
) ();

  localparam int IW = idx_width(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] data;
  logic [N_REQ-1:0] gnt;
  logic             bus_oe;
  logic             bus_out;
  logic             z_state;
  logic [IW-1:0]    owner_id;

  modport master (
    output req,
    output data,
    input  gnt,
    input  bus_oe,
    input  bus_out,
    input  z_state,
    input  owner_id
  );

  modport slave (
    input  req,
    input  data,
    output gnt,
    output bus_oe,
    output bus_out,
    output z_state,
    output owner_id
  );

endinterface

// File: rtl/tristate_bus_arbiter_rr_picker.sv
// Round-robin pick: first requester after rr_ptr_i, wrapping, so the last owner ranks lowest.
module rr_picker
  import tristate_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    rr_ptr_i,
  output logic             valid_o,
  output logic [IW-1:0]    idx_o
);

  logic hit;
  int   pos;

  assign valid_o = |req_i;

  always_comb begin
    idx_o = '0;
    hit   = 1'b0;
    pos   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = (int'(rr_ptr_i) + k) % N_REQ;
      if (!hit && req_i[pos]) begin
        hit   = 1'b1;
        idx_o = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Shares one tristate line between N_REQ requesters: round-robin ownership,
// bounded hold time and forced released cycles between different drivers.
module tristate_bus_arbiter
  import tristate_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  tristate_bus_arbiter_if.slave bus_if
);

  localparam int IW = idx_width(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURNAROUND + 1);

  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [TW-1:0] TA_LOAD  = TW'(TURNAROUND);

  arb_state_e       state_q;
  logic [IW-1:0]    owner_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [HW-1:0]    hold_q;
  logic [HW-1:0]    hold_d;
  logic [TW-1:0]    ta_q;
  logic [N_REQ-1:0] gnt_q;
  logic             oe_q;

  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic             others_wait;
  logic             release_req;

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req_i    (bus_if.req),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx)
  );

  assign hold_d      = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
  assign others_wait = |(bus_if.req & ~gnt_q);
  // A dropped request wins over the hold limit; both lead to the same release.
  assign release_req = !bus_if.req[owner_q] || ((hold_q == HOLD_MAX) && others_wait);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= IW'(N_REQ - 1);
      hold_q   <= '0;
      ta_q     <= '0;
      gnt_q    <= '0;
      oe_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q <= ST_GRANT;
            owner_q <= pick_idx;
            gnt_q   <= N_REQ'(1) << pick_idx;
            oe_q    <= 1'b1;
            hold_q  <= HW'(1);
          end
        end
        ST_GRANT: begin
          if (release_req) begin
            state_q  <= ST_TURN;
            ta_q     <= TA_LOAD;
            rr_ptr_q <= owner_q;
            owner_q  <= '0;
            gnt_q    <= '0;
            oe_q     <= 1'b0;
          end else begin
            hold_q <= hold_d;
          end
        end
        ST_TURN: begin
          if (ta_q == TW'(1)) begin
            ta_q <= '0;
            if (pick_valid) begin
              state_q <= ST_GRANT;
              owner_q <= pick_idx;
              gnt_q   <= N_REQ'(1) << pick_idx;
              oe_q    <= 1'b1;
              hold_q  <= HW'(1);
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            ta_q <= ta_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_if.gnt      = gnt_q;
  assign bus_if.bus_oe   = oe_q;
  assign bus_if.bus_out  = oe_q & bus_if.data[owner_q];
  assign bus_if.z_state  = ~oe_q;
  assign bus_if.owner_id = owner_q;

  // Released cycles since the last driven cycle; reset counts as a full turnaround.
  logic [TW-1:0] z_run_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      z_run_q <= TA_LOAD;
    end else if (oe_q) begin
      z_run_q <= '0;
    end else if (z_run_q != TA_LOAD) begin
      z_run_q <= z_run_q + 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt_q));
      assert (bus_if.bus_oe == |bus_if.gnt);
      assert (bus_if.z_state == !bus_if.bus_oe);
      if (oe_q && (z_run_q != '0)) assert (z_run_q == TA_LOAD);
    end
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: two configurations checked against an ownership model every cycle.
module tb_tristate_bus_arbiter;

  logic clk;
  logic rst;
  logic chk_en;
  int   n_chk;
  int   n_err;

  tristate_bus_arbiter_if #(.N_REQ(4)) if_a ();
  tristate_bus_arbiter_if #(.N_REQ(2)) if_b ();

  tristate_bus_arbiter #(.N_REQ(4), .TURNAROUND(1), .MAX_HOLD(8)) u_a (
    .clk    (clk),
    .rst    (rst),
    .bus_if (if_a.slave)
  );

  tristate_bus_arbiter #(.N_REQ(2), .TURNAROUND(3), .MAX_HOLD(8)) u_b (
    .clk    (clk),
    .rst    (rst),
    .bus_if (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // owner < 0 means nobody drives; turn counts remaining released cycles.
  typedef struct {
    int owner;
    int hold;
    int turn;
    int last;
  } model_t;

  model_t ma;
  model_t mb;

  function automatic int rr_pick(input logic [15:0] r, input int last, input int n);
    for (int k = 1; k <= n; k++) begin
      if (r[(last + k) % n]) return (last + k) % n;
    end
    return -1;
  endfunction

  function automatic model_t m_step(input model_t m, input logic [15:0] r, input logic rs,
                                    input int n, input int ta, input int mh);
    model_t x;
    logic [15:0] others;
    x = m;
    if (rs) begin
      x.owner = -1;
      x.hold  = 0;
      x.turn  = 0;
      x.last  = n - 1;
      return x;
    end
    if (m.owner >= 0) begin
      others = r & ~(16'(1) << m.owner);
      if (!r[m.owner] || (m.hold == mh && others != 0)) begin
        x.last  = m.owner;
        x.owner = -1;
        x.turn  = ta;
      end else if (m.hold < mh) begin
        x.hold = m.hold + 1;
      end
    end else if (m.turn > 1) begin
      x.turn = m.turn - 1;
    end else begin
      x.turn = 0;
      if (r != 0) begin
        x.owner = rr_pick(r, m.last, n);
        x.hold  = 1;
      end
    end
    return x;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    ma <= m_step(ma, 16'(if_a.req), rst, 4, 1, 8);
    mb <= m_step(mb, 16'(if_b.req), rst, 2, 3, 8);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_gnt", int'(if_a.gnt), (ma.owner >= 0) ? (1 << ma.owner) : 0);
      chk("a_oe", int'(if_a.bus_oe), (ma.owner >= 0) ? 1 : 0);
      chk("a_z", int'(if_a.z_state), (ma.owner >= 0) ? 0 : 1);
      chk("a_owner", int'(if_a.owner_id), (ma.owner >= 0) ? ma.owner : 0);
      chk("a_bus_out", int'(if_a.bus_out), (ma.owner >= 0) ? int'(if_a.data[ma.owner]) : 0);
      chk("b_gnt", int'(if_b.gnt), (mb.owner >= 0) ? (1 << mb.owner) : 0);
      chk("b_oe", int'(if_b.bus_oe), (mb.owner >= 0) ? 1 : 0);
      chk("b_z", int'(if_b.z_state), (mb.owner >= 0) ? 0 : 1);
      chk("b_owner", int'(if_b.owner_id), (mb.owner >= 0) ? mb.owner : 0);
      chk("b_bus_out", int'(if_b.bus_out), (mb.owner >= 0) ? int'(if_b.data[mb.owner]) : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int exp;
    int p;
    n_chk     = 0;
    n_err     = 0;
    chk_en    = 1'b0;
    rst       = 1'b1;
    if_a.req  = '0;
    if_a.data = '0;
    if_b.req  = '0;
    if_b.data = '0;
    tick();
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;

    chk("rst_gnt", int'(if_a.gnt), 0);
    chk("rst_z", int'(if_a.z_state), 1);
    chk("rst_owner", int'(if_a.owner_id), 0);

    // single requester, data toggling, release and return to idle
    if_a.req = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c <= 6) begin
        chk("t1_gnt", int'(if_a.gnt), 1);
        chk("t1_bus_out", int'(if_a.bus_out), (c - 1) & 1);
      end else begin
        chk("t1_oe", int'(if_a.bus_oe), 0);
        chk("t1_z", int'(if_a.z_state), 1);
      end
      if_a.data = 4'(c & 1);
      if (c == 6) if_a.req = 4'b0000;
    end
    if_a.req = 4'b0010;
    tick();
    chk("t1_idle_lat", int'(if_a.gnt), 2);
    if_a.req = '0;
    tick();
    tick();

    // handover after three grant cycles
    do_reset();
    if_a.req = 4'b0011;
    for (int c = 1; c <= 5; c++) begin
      tick();
      exp = (c <= 3) ? 1 : (c == 4) ? 0 : 2;
      chk("t2_gnt", int'(if_a.gnt), exp);
      if (c == 4) chk("t2_z", int'(if_a.z_state), 1);
      if (c == 3) if_a.req = 4'b0010;
    end
    if_a.req = '0;
    tick();
    tick();

    // all four requesting: 8-cycle slots, one released cycle between
    do_reset();
    if_a.req = 4'b1111;
    for (int c = 1; c <= 60; c++) begin
      tick();
      p   = (c - 1) % 9;
      exp = (p == 8) ? 0 : (1 << (((c - 1) / 9) % 4));
      chk("t3_rr_gnt", int'(if_a.gnt), exp);
      if_a.data = 4'($urandom);
    end
    if_a.req = '0;
    tick();
    tick();

    // three-cycle turnaround on the two-requester instance
    do_reset();
    if_b.req = 2'b11;
    for (int c = 1; c <= 7; c++) begin
      tick();
      exp = (c <= 3) ? 1 : (c <= 6) ? 0 : 2;
      chk("t4_gnt", int'(if_b.gnt), exp);
      if (c >= 4 && c <= 6) chk("t4_z", int'(if_b.z_state), 1);
      if (c == 3) if_b.req = 2'b10;
    end
    if_b.req = '0;
    tick();
    tick();

    // reset while requester 2 owns the bus
    do_reset();
    if_a.req = 4'b0100;
    tick();
    chk("t5_gnt_pre", int'(if_a.gnt), 4);
    tick();
    chk("t5_gnt_pre2", int'(if_a.gnt), 4);
    rst      = 1'b1;
    if_a.req = 4'b1111;
    tick();
    rst = 1'b0;
    chk("t5_gnt_rst", int'(if_a.gnt), 0);
    chk("t5_oe_rst", int'(if_a.bus_oe), 0);
    chk("t5_owner_rst", int'(if_a.owner_id), 0);
    tick();
    chk("t5_first", int'(if_a.gnt), 1);
    if_a.req = '0;
    tick();
    tick();

    // sole requester past MAX_HOLD keeps the bus
    do_reset();
    if_a.req = 4'b0001;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk("t6_sat_gnt", int'(if_a.gnt), 1);
      if_a.data = 4'($urandom);
    end
    if_a.req = '0;
    tick();
    tick();

    // sticky random traffic on both instances, occasional reset
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) if_a.req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) if_b.req = 2'($urandom);
      if_a.data = 4'($urandom);
      if_b.data = 2'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst      = 1'b0;
    if_a.req = '0;
    if_b.req = '0;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Shares one tristate bus line (dir/ctrl-style driver: output enable plus drive value) between N_REQ requesters.
- Grants ownership round-robin and drives the tristate cell's enable and data from the owner.
- Inserts mandatory all-released turnaround cycles between owners so two drivers never overlap.
- Sits directly in front of the tristate cell; its bus_oe/bus_out map onto the cell's dir/ctrl.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- TURNAROUND, 1, released (Z) cycles between owners (>=1).
- MAX_HOLD, 8, max consecutive grant cycles before forced release when another requester waits (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  level request per requester; held while the requester wants the bus.
- data  in  N_REQ  per-requester value to drive when owner.
- gnt  out  N_REQ  one-hot grant; all zero when no owner.
- bus_oe  out  1  output enable to tristate cell (1 = drive).
- bus_out  out  1  value to drive; equals data[owner] when bus_oe=1, else 0.
- z_state  out  1  1 when bus is released (bus_oe=0).
- owner_id  out  $clog2(N_REQ)  index of current owner; 0 when none.

Behaviour:
- Reset: state=IDLE, gnt=0, bus_oe=0, bus_out=0, z_state=1, owner_id=0, rr_ptr=N_REQ-1 (req[0] has first priority), hold_cnt=0, ta_cnt=0. Reset mid-grant releases the bus on the cycle after the reset edge.
- Outputs are decoded from registered state/owner only. bus_out is the combinational mux of data[owner] gated by bus_oe. There is no combinational path from req to gnt.
- IDLE: bus released.
  - If any req is high at the edge: owner <= rr-pick, state <= GRANT, hold_cnt <= 1.
  - Grant latency from IDLE is 1 cycle.
- GRANT: gnt[owner]=1, bus_oe=1, z_state=0. hold_cnt increments, saturating at MAX_HOLD.
  - Release condition: req[owner]=0, or (hold_cnt==MAX_HOLD and any other req high).
  - On release: state <= TURN, ta_cnt <= TURNAROUND, rr_ptr <= owner. gnt/bus_oe drop on the next cycle.
- TURN: bus released, gnt=0, ta_cnt decrements each cycle.
  - When ta_cnt==1: if any req, go to GRANT with a new rr-pick; else go to IDLE.
  - The re-asserting previous owner is eligible, but at lowest priority.
- rr-pick: first index i with req[i]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo N_REQ (wraps past N_REQ-1 to 0).
- Invariants (assert in RTL):
  - At most one gnt bit is high.
  - bus_oe == |gnt.
  - z_state == !bus_oe.
  - Between any two different owners' grants there are at least TURNAROUND cycles with bus_oe=0.
- MAX_HOLD with no other requester waiting: the owner keeps the bus indefinitely (hold_cnt saturates).
- req dropping and another req rising on the same edge: release takes precedence; the new requester is arbitrated at the end of TURN.

Decomposition:
- Package tristate_arb_pkg:
  - state enum {IDLE, GRANT, TURN};
  - function for owner index width.
- Sub-module rr_picker (N_REQ param): inputs req and rr_ptr; outputs valid and idx. Purely combinational rotate-and-priority-encode.
- The FSM, counters and output decode live in tristate_bus_arbiter.

Test Plan:
- Single requester, defaults: req=0001 before edge 1, data[0] toggles each cycle. Required: gnt=0001, bus_oe=1 from cycle 1, bus_out follows data[0]. Drop req at edge 6 -> bus_oe=0, z_state=1 from cycle 7, state IDLE after 1 TURN cycle.
- Handover: req=0011 continuously, req[0] drops after 3 grant cycles. Required: gnt 0001 for 3 cycles, then exactly 1 cycle gnt=0000/z_state=1, then gnt=0010.
- Round robin fairness with MAX_HOLD=8: req=1111 held for 60 cycles. Required: grant order 0,1,2,3,0,...; each grant lasts exactly 8 cycles with 1 Z cycle between; no overlap of bus_oe across owners.
- TURNAROUND=3, N_REQ=2: req[0] drops while req[1] is high. Required: exactly 3 consecutive z_state=1 cycles before gnt=10.
- Reset mid-grant: rst=1 for one edge while gnt=0100. Required: next cycle gnt=0, bus_oe=0, owner_id=0. With req=1111 after reset, the first grant is 0001.
- Saturation: sole requester held 20 cycles, MAX_HOLD=8. Required: no release; gnt stays continuous for all 20 cycles.
